// File: rtl/data_path.sv
// Single-bus 32-bit CPU datapath: general registers, PC, IR, MAR, MDR, Y and Zlow
// sharing one combinational bus, with a combinational ALU feeding Zlow.
module data_path #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             R1in,
  input  logic             R2in,
  input  logic             R3in,
  input  logic             R1out,
  input  logic             R2out,
  input  logic             R3out,
  input  logic             PCin,
  input  logic             PCout,
  input  logic             IncPC,
  input  logic             IRin,
  input  logic             MARin,
  input  logic             MDRin,
  input  logic             MDRout,
  input  logic             MD_read,
  input  logic             Yin,
  input  logic             Zlowin,
  input  logic             Zlowout,
  input  logic [2:0]       ALU_op,
  input  logic [WIDTH-1:0] Mdatain,
  output logic [WIDTH-1:0] BusMuxOut,
  output logic [WIDTH-1:0] MAR_q,
  output logic [WIDTH-1:0] IR_q
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NEG = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  logic [WIDTH-1:0] r1, r2, r3, pc, ir, mar, mdr, y, zlow;
  logic [WIDTH-1:0] md_mux;
  logic [WIDTH-1:0] alu_result;

  // Arithmetic wraps modulo 2^WIDTH; no flags are produced.
  function automatic logic [WIDTH-1:0] alu_calc(
    input logic [2:0]       op,
    input logic             inc,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic        [WIDTH-1:0] res;
    sa  = a;
    sb  = b;
    res = '0;
    if (inc) begin
      res = b + WIDTH'(1);
    end else begin
      case (op)
        OP_ADD:  res = sa + sb;
        OP_SUB:  res = sa - sb;
        OP_AND:  res = a & b;
        OP_OR:   res = a | b;
        OP_NEG:  res = -sb;
        OP_NOT:  res = ~b;
        OP_SHL:  res = a << b[4:0];
        OP_SHR:  res = a >> b[4:0];
        default: res = '0;
      endcase
    end
    return res;
  endfunction

  // Fixed-priority bus mux; an idle bus reads as zero.
  always_comb begin
    BusMuxOut = '0;
    if (MDRout)       BusMuxOut = mdr;
    else if (Zlowout) BusMuxOut = zlow;
    else if (PCout)   BusMuxOut = pc;
    else if (R1out)   BusMuxOut = r1;
    else if (R2out)   BusMuxOut = r2;
    else if (R3out)   BusMuxOut = r3;
  end

  assign md_mux     = MD_read ? Mdatain : BusMuxOut;
  assign alu_result = alu_calc(ALU_op, IncPC, y, BusMuxOut);

  // Register stage: every load samples the same bus value; clear overrides all enables.
  always_ff @(posedge clock) begin
    if (clear) begin
      r1   <= '0;
      r2   <= '0;
      r3   <= '0;
      pc   <= '0;
      ir   <= '0;
      mar  <= '0;
      mdr  <= '0;
      y    <= '0;
      zlow <= '0;
    end else begin
      if (R1in)   r1   <= BusMuxOut;
      if (R2in)   r2   <= BusMuxOut;
      if (R3in)   r3   <= BusMuxOut;
      if (PCin)   pc   <= BusMuxOut;
      if (IRin)   ir   <= BusMuxOut;
      if (MARin)  mar  <= BusMuxOut;
      if (MDRin)  mdr  <= md_mux;
      if (Yin)    y    <= BusMuxOut;
      if (Zlowin) zlow <= alu_result;
    end
  end

  assign MAR_q = mar;
  assign IR_q  = ir;

endmodule

// File: tb/tb_data_path.sv
// Directed bench for data_path: register loads, fetch, ALU ops, bus priority and reset.
module tb_data_path;

  logic        clock = 1'b0;
  logic        clear;
  logic        R1in, R2in, R3in, R1out, R2out, R3out;
  logic        PCin, PCout, IncPC, IRin, MARin, MDRin, MDRout, MD_read;
  logic        Yin, Zlowin, Zlowout;
  logic [2:0]  ALU_op;
  logic [31:0] Mdatain;
  logic [31:0] BusMuxOut, MAR_q, IR_q;

  int checks   = 0;
  int failures = 0;

  data_path #(.WIDTH(32)) dut (
    .clock(clock), .clear(clear),
    .R1in(R1in), .R2in(R2in), .R3in(R3in),
    .R1out(R1out), .R2out(R2out), .R3out(R3out),
    .PCin(PCin), .PCout(PCout), .IncPC(IncPC), .IRin(IRin),
    .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .MD_read(MD_read),
    .Yin(Yin), .Zlowin(Zlowin), .Zlowout(Zlowout),
    .ALU_op(ALU_op), .Mdatain(Mdatain),
    .BusMuxOut(BusMuxOut), .MAR_q(MAR_q), .IR_q(IR_q)
  );

  always #5 clock = ~clock;

  task automatic idle();
    clear = 0; R1in = 0; R2in = 0; R3in = 0; R1out = 0; R2out = 0; R3out = 0;
    PCin = 0; PCout = 0; IncPC = 0; IRin = 0; MARin = 0; MDRin = 0; MDRout = 0;
    MD_read = 0; Yin = 0; Zlowin = 0; Zlowout = 0; ALU_op = 3'b000; Mdatain = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Settle combinational bus for the strobes just applied, then compare.
  task automatic check_bus(input string tag, input logic [31:0] exp);
    #1;
    check(tag, BusMuxOut, exp);
  endtask

  task automatic load_mdr_from_mem(input logic [31:0] val);
    idle(); Mdatain = val; MD_read = 1; MDRin = 1; tick();
  endtask

  // Y holds operand A; R3 drives B; result goes through Zlow and is read back on the bus.
  task automatic alu_step(input string tag, input logic [2:0] op, input logic inc,
                          input logic [31:0] exp);
    idle(); R3out = 1; ALU_op = op; IncPC = inc; Zlowin = 1; tick();
    idle(); Zlowout = 1; check_bus(tag, exp);
  endtask

  initial begin
    idle();
    clear = 1;
    tick();
    idle();
    check("rst_bus_idle", BusMuxOut, 32'h0);
    check("rst_mar", MAR_q, 32'h0);
    check("rst_ir", IR_q, 32'h0);
    idle(); R1out = 1; check_bus("rst_r1", 32'h0);
    idle(); MDRout = 1; check_bus("rst_mdr", 32'h0);

    // Register loads through MDR
    load_mdr_from_mem(32'h6);
    idle(); MDRout = 1; R2in = 1; tick();
    load_mdr_from_mem(32'h14);
    idle(); MDRout = 1; R3in = 1; tick();
    load_mdr_from_mem(32'h18);
    idle(); MDRout = 1; R1in = 1; tick();
    idle(); R2out = 1; check_bus("load_r2", 32'h6);
    idle(); R3out = 1; check_bus("load_r3", 32'h14);
    idle(); R1out = 1; check_bus("load_r1", 32'h18);

    // Fetch
    idle(); PCout = 1; MARin = 1; IncPC = 1; Zlowin = 1;
    check_bus("fetch_pc_bus", 32'h0);
    tick();
    idle();
    check("fetch_mar", MAR_q, 32'h0);
    Zlowout = 1; check_bus("fetch_zlow", 32'h1);
    Zlowout = 1; PCin = 1; MD_read = 1; MDRin = 1; Mdatain = 32'h2; tick();
    idle(); PCout = 1; check_bus("fetch_pc", 32'h1);
    idle(); MDRout = 1; check_bus("fetch_mdr", 32'h2);
    idle(); MDRout = 1; IRin = 1; tick();
    idle();
    check("fetch_ir", IR_q, 32'h2);
    idle(); R3out = 1; MARin = 1; tick();
    idle();
    check("mar_load", MAR_q, 32'h14);

    // NEG, then result back into R1
    idle(); R2out = 1; Yin = 1; tick();
    alu_step("neg", 3'b100, 1'b0, 32'hFFFF_FFEC);
    idle(); Zlowout = 1; R1in = 1; tick();
    idle(); R1out = 1; check_bus("neg_r1", 32'hFFFF_FFEC);

    // ALU ops with Y=6, B=R3=0x14
    alu_step("add", 3'b000, 1'b0, 32'h0000_001A);
    alu_step("sub", 3'b001, 1'b0, 32'hFFFF_FFF2);
    alu_step("and", 3'b010, 1'b0, 32'h0000_0004);
    alu_step("or",  3'b011, 1'b0, 32'h0000_0016);
    alu_step("not", 3'b101, 1'b0, 32'hFFFF_FFEB);
    alu_step("incpc_overrides_sub", 3'b001, 1'b1, 32'h0000_0015);

    // Shifts with Y=0x18, then Y=0x01800000
    load_mdr_from_mem(32'h18);
    idle(); MDRout = 1; Yin = 1; tick();
    alu_step("shl", 3'b110, 1'b0, 32'h0180_0000);
    idle(); Zlowout = 1; Yin = 1; tick();
    alu_step("shr", 3'b111, 1'b0, 32'h0000_0018);

    // Wrap-around: Y=0xFFFFFFEC + 0x14
    idle(); R1out = 1; Yin = 1; tick();
    alu_step("add_wrap", 3'b000, 1'b0, 32'h0);

    // Bus priority and idle bus (MDR=0x18, Zlow=0, PC=1)
    idle(); MDRout = 1; R2out = 1; check_bus("prio_mdr_r2", 32'h18);
    idle(); PCout = 1; R1out = 1; check_bus("prio_pc_r1", 32'h1);
    idle(); R2out = 1; R3out = 1; check_bus("prio_r2_r3", 32'h6);
    idle(); check_bus("bus_idle", 32'h0);

    // Read-modify-write keeps R1; parallel loads from one bus value
    idle(); R1out = 1; R1in = 1; tick();
    idle(); R1out = 1; check_bus("rmw_r1", 32'hFFFF_FFEC);
    idle(); R3out = 1; R1in = 1; R2in = 1; tick();
    idle(); R1out = 1; check_bus("par_r1", 32'h14);
    idle(); R2out = 1; check_bus("par_r2", 32'h14);

    // Synchronous reset with a competing load enable
    idle(); Mdatain = 32'hAB; MD_read = 1; MDRin = 1; IRin = 1; R3out = 1; Yin = 1; tick();
    idle(); clear = 1; R1in = 1; R3out = 1;
    #1;
    check("pre_clear_mar", MAR_q, 32'h14);
    check("pre_clear_bus", BusMuxOut, 32'h14);
    tick();
    idle();
    check("clr_bus_idle", BusMuxOut, 32'h0);
    check("clr_mar", MAR_q, 32'h0);
    check("clr_ir", IR_q, 32'h0);
    idle(); R1out = 1; check_bus("clr_r1", 32'h0);
    idle(); R2out = 1; check_bus("clr_r2", 32'h0);
    idle(); R3out = 1; check_bus("clr_r3", 32'h0);
    idle(); PCout = 1; check_bus("clr_pc", 32'h0);
    idle(); MDRout = 1; check_bus("clr_mdr", 32'h0);
    idle(); Zlowout = 1; check_bus("clr_zlow", 32'h0);
    idle(); Zlowin = 1; tick();
    idle(); Zlowout = 1; check_bus("clr_y", 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
